// File: rtl/alu_op_sequencer.sv
// Sequences one request at a time into the 8-bit ALU; logic ops take one RUN cycle, shifts/rotates one 1-bit step per cycle.
// Latency: logic 1 edge after accept, shift amt=k k edges, amt=0/illegal immediate; the response is held in DONE until rsp_ready.
module alu_op_sequencer #(
  parameter int W     = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [AMT_W-1:0] req_amt,
  output logic [2:0]       alu_cmd,
  output logic [1:0]       sel_cmd,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic             alu_sc_i,
  input  logic [W-1:0]     alu_rslt,
  input  logic             alu_sc_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_ROL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_ILL = 3'b111;

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_SLL = 3'b110;
  localparam logic [2:0] CMD_SRL = 3'b101;
  localparam logic [2:0] CMD_OR  = 3'b010;
  localparam logic [2:0] CMD_XOR = 3'b011;
  localparam logic [2:0] CMD_AND = 3'b100;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [W-1:0]       work_q, work_d;
  logic [W-1:0]       b_q, b_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_SLL;
      work_q  <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      op_q    <= op_d;
      work_q  <= work_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    work_d    = work_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_cmd   = CMD_NOP;
    alu_a     = '0;
    alu_b     = '0;
    alu_sc_i  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          op_d    = req_op;
          b_d     = req_b;
          cnt_d   = req_amt;
          carry_d = 1'b0;
          err_d   = 1'b0;
          work_d  = req_a;
          if (req_op == OP_ILL) begin
            // Illegal ops report a zero result rather than echoing operand A.
            err_d   = 1'b1;
            work_d  = '0;
            state_d = S_DONE;
          end else if (!req_op[2] && (req_amt == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        alu_a  = work_q;
        work_d = alu_rslt;
        unique case (op_q)
          OP_SLL: alu_cmd = CMD_SLL;
          OP_SRL: alu_cmd = CMD_SRL;
          OP_ROL: begin
            alu_cmd  = CMD_SLL;
            alu_sc_i = work_q[W-1];
          end
          OP_ROR: begin
            alu_cmd  = CMD_SRL;
            alu_sc_i = work_q[0];
          end
          OP_OR: begin
            alu_cmd = CMD_OR;
            alu_b   = b_q;
          end
          OP_XOR: begin
            alu_cmd = CMD_XOR;
            alu_b   = b_q;
          end
          OP_AND: begin
            alu_cmd = CMD_AND;
            alu_b   = b_q;
          end
          default: alu_cmd = CMD_NOP;
        endcase
        if (op_q[2]) begin
          state_d = S_DONE;
        end else begin
          carry_d = alu_sc_o;
          cnt_d   = cnt_q - AMT_W'(1);
          if (cnt_q == AMT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Response fields come straight from registers, so they stay stable across DONE.
  assign rsp_data  = work_q;
  assign rsp_carry = carry_q;
  assign rsp_zero  = (work_q == '0);
  assign rsp_err   = err_q;
  assign sel_cmd   = 2'b00;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU, a table of directed vectors,
// hand-written reset/backpressure sequences and random requests against a reference model.
module tb_alu_op_sequencer;
  localparam int W = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_op = 3'd0;
  logic [W-1:0]     req_a = '0;
  logic [W-1:0]     req_b = '0;
  logic [AMT_W-1:0] req_amt = '0;
  logic [2:0]       alu_cmd;
  logic [1:0]       sel_cmd;
  logic [W-1:0]     alu_a, alu_b;
  logic             alu_sc_i;
  logic [W-1:0]     alu_rslt;
  logic             alu_sc_o;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [W-1:0]     rsp_data;
  logic             rsp_carry, rsp_zero, rsp_err;

  always #5 clk = ~clk;

  alu_op_sequencer #(.W(W), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_amt(req_amt),
    .alu_cmd(alu_cmd), .sel_cmd(sel_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Behavioural ALU
  always_comb begin
    alu_rslt = '0;
    alu_sc_o = 1'b0;
    case (alu_cmd)
      3'b110: begin alu_rslt = {alu_a[W-2:0], alu_sc_i}; alu_sc_o = alu_a[W-1]; end
      3'b101: begin alu_rslt = {alu_sc_i, alu_a[W-1:1]}; alu_sc_o = alu_a[0]; end
      3'b010: alu_rslt = alu_a | alu_b;
      3'b011: alu_rslt = alu_a ^ alu_b;
      3'b100: alu_rslt = alu_a & alu_b;
      default: alu_rslt = '0;
    endcase
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: result of a whole request computed in one go.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] amt, output logic [7:0] d, output logic c,
                                output logic z, output logic e, output int lat);
    logic [15:0] t;
    d = 8'h00; c = 1'b0; e = 1'b0; lat = int'(amt);
    case (op)
      3'd0: begin t = {8'h00, a} << amt; d = t[7:0];  c = (amt != 0) ? t[8] : 1'b0; end
      3'd1: begin t = {a, 8'h00} >> amt; d = t[15:8]; c = (amt != 0) ? t[7] : 1'b0; end
      3'd2: begin t = {a, a} << amt;     d = t[15:8]; c = (amt != 0) ? d[0] : 1'b0; end
      3'd3: begin t = {a, a} >> amt;     d = t[7:0];  c = (amt != 0) ? d[7] : 1'b0; end
      3'd4: begin d = a | b; lat = 1; end
      3'd5: begin d = a ^ b; lat = 1; end
      3'd6: begin d = a & b; lat = 1; end
      default: begin d = 8'h00; e = 1'b1; lat = 0; end
    endcase
    z = (d == 8'h00);
  endfunction

  function automatic logic [2:0] exp_cmd(input logic [2:0] op);
    case (op)
      3'd0, 3'd2: return 3'b110;
      3'd1, 3'd3: return 3'b101;
      3'd4:       return 3'b010;
      3'd5:       return 3'b011;
      3'd6:       return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // Issue one request, watch RUN cycles, hold the response for `hold` cycles, then accept it.
  task automatic run_req(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] amt, input int hold,
                         output logic [7:0] d, output logic c, output logic z,
                         output logic e, output int lat);
    logic [7:0] wv, md;
    logic mc, mz, me, exp_sc;
    int ml;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_op = op; req_a = a; req_b = b; req_amt = amt; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_op = 3'd7; req_a = 8'hEE; req_b = 8'hEE; req_amt = 3'd5;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      model(op, a, b, 3'(lat), wv, mc, mz, me, ml);
      exp_sc = (op == 3'd2) ? wv[7] : (op == 3'd3) ? wv[0] : 1'b0;
      check("run_sc_i", alu_sc_i, exp_sc);
      check("run_cmd", alu_cmd, exp_cmd(op));
      @(posedge clk);
      #1 lat++;
    end
    d = rsp_data; c = rsp_carry; z = rsp_zero; e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, d);
      check("hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("rsp_valid_drop", rsp_valid, 0);
    check("idle_req_ready", req_ready, 1);
    md = 8'h00;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] amt;
    logic [7:0] d;
    logic       c;
    logic       z;
    logic       e;
    int         lat;
  } vec_t;

  vec_t tbl[13];

  task automatic check_reset_values();
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_carry", rsp_carry, 0);
    check("rst_rsp_zero", rsp_zero, 1);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_alu_cmd", alu_cmd, 0);
    check("rst_sel_cmd", sel_cmd, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sc_i", alu_sc_i, 0);
  endtask

  initial begin
    logic [7:0] d, md;
    logic c, z, e, mc, mz, me;
    int lat, ml;
    logic [2:0] rop, ramt;
    logic [7:0] ra, rb;

    tbl[0]  = '{3'd0, 8'h81, 8'h00, 3'd1, 8'h02, 1'b1, 1'b0, 1'b0, 1};
    tbl[1]  = '{3'd1, 8'h81, 8'h00, 3'd3, 8'h10, 1'b0, 1'b0, 1'b0, 3};
    tbl[2]  = '{3'd2, 8'h96, 8'h00, 3'd3, 8'hB4, 1'b0, 1'b0, 1'b0, 3};
    tbl[3]  = '{3'd3, 8'h01, 8'h00, 3'd1, 8'h80, 1'b1, 1'b0, 1'b0, 1};
    tbl[4]  = '{3'd5, 8'h5A, 8'h5A, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1};
    tbl[5]  = '{3'd6, 8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0, 1'b0, 1};
    tbl[6]  = '{3'd0, 8'h7F, 8'h00, 3'd0, 8'h7F, 1'b0, 1'b0, 1'b0, 0};
    tbl[7]  = '{3'd7, 8'h7F, 8'hAA, 3'd5, 8'h00, 1'b0, 1'b1, 1'b1, 0};
    tbl[8]  = '{3'd4, 8'h0F, 8'hF0, 3'd7, 8'hFF, 1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{3'd0, 8'h01, 8'h00, 3'd7, 8'h80, 1'b0, 1'b0, 1'b0, 7};
    tbl[10] = '{3'd0, 8'hFF, 8'h00, 3'd7, 8'h80, 1'b1, 1'b0, 1'b0, 7};
    tbl[11] = '{3'd1, 8'h80, 8'h00, 3'd7, 8'h01, 1'b0, 1'b0, 1'b0, 7};
    tbl[12] = '{3'd3, 8'hA5, 8'h00, 3'd7, 8'h4B, 1'b0, 1'b0, 1'b0, 7};

    #2;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_req(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].amt, i % 3, d, c, z, e, lat);
      check($sformatf("vec%0d_data", i), d, tbl[i].d);
      check($sformatf("vec%0d_carry", i), c, tbl[i].c);
      check($sformatf("vec%0d_zero", i), z, tbl[i].z);
      check($sformatf("vec%0d_err", i), e, tbl[i].e);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
    end

    // Reset in the third RUN cycle of a 7-step shift.
    @(negedge clk);
    req_op = 3'd0; req_a = 8'h01; req_b = 8'h00; req_amt = 3'd7; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    run_req(3'd0, 8'h01, 8'h00, 3'd2, 0, d, c, z, e, lat);
    check("post_rst_data", d, 8'h04);
    check("post_rst_lat", lat, 2);

    // Backpressure: response held 5 cycles while a new request waits.
    @(negedge clk);
    req_op = 3'd5; req_a = 8'h33; req_b = 8'h0F; req_amt = 3'd0; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp_valid", rsp_valid, 1);
    check("bp_data", rsp_data, 8'h3C);
    @(negedge clk);
    req_op = 3'd6; req_a = 8'hFF; req_b = 8'h0F; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, 8'h3C);
      check("bp_hold_zero", rsp_zero, 0);
      check("bp_hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("bp_release_valid", rsp_valid, 0);
    check("bp_release_req_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("bp_new_accepted", req_ready, 0);
    @(posedge clk);
    #1;
    check("bp_new_valid", rsp_valid, 1);
    check("bp_new_data", rsp_data, 8'h0F);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra = 8'($urandom);
      rb = 8'($urandom);
      ramt = 3'($urandom_range(0, 7));
      model(rop, ra, rb, ramt, md, mc, mz, me, ml);
      run_req(rop, ra, rb, ramt, $urandom_range(0, 2), d, c, z, e, lat);
      check("rnd_data", d, md);
      check("rnd_carry", c, mc);
      check("rnd_zero", z, mz);
      check("rnd_err", e, me);
      check("rnd_lat", lat, ml);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller in front of the 8-bit combinational ALU. It accepts one operation request at a time over a valid/ready handshake. Logic ops issue to the ALU in a single cycle. Multi-bit shifts and rotates are built from repeated 1-bit ALU shifts, with the working value and carry fed back each cycle. It sits between the decode/execute control and the ALU, and is the only driver of the ALU command and operand inputs.

## Interface
- W, 8: datapath width; must match the ALU.
- AMT_W, 3: shift-amount width; shifts of 0..2^AMT_W-1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  000 SLL, 001 SRL, 010 ROL, 011 ROR, 100 OR, 101 XOR, 110 AND, 111 illegal.
- req_a  in  W  operand A; the value shifted for shift/rotate ops.
- req_b  in  W  operand B; used by logic ops only.
- req_amt  in  AMT_W  shift count; ignored for logic ops.
- alu_cmd  out  3  to ALU: 110 SLL step, 101 SRL step, 010 OR, 011 XOR, 100 AND; 000 when idle.
- sel_cmd  out  2  to ALU; always 00.
- alu_a, alu_b  out  W  ALU inA/inB.
- alu_sc_i  out  1  ALU shift-carry in (fill bit).
- alu_rslt  in  W  ALU result.
- alu_sc_o  in  1  ALU shift-carry out (bit shifted out).
- rsp_valid  out  1  response present; held until accepted.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  W  final result.
- rsp_carry  out  1  last bit shifted out; 0 for logic ops and for amt=0.
- rsp_zero  out  1  rsp_data == 0.
- rsp_err  out  1  illegal op; rsp_data=0, carry=0, zero=1.

## Operation
- ALU contract: a shift step returns inA shifted one place, with sc_i filling the vacated bit and sc_o holding the bit shifted out. Logic ops are bitwise on inA and inB.
- States: IDLE, RUN, DONE.
- IDLE: req_ready=1. On req_valid:
  - capture op, a, b, amt into registers: work<=req_a, cnt<=req_amt, carry<=0.
  - Illegal op or shift with amt=0 -> DONE (err=1 for illegal; data=req_a for amt=0).
  - Otherwise -> RUN.
- RUN, logic op: drive alu_cmd per op, alu_a=work, alu_b=b. At the edge, work<=alu_rslt, -> DONE.
- RUN, shift/rotate: drive the step command, with alu_a=work and alu_sc_i as follows:
  - SLL/SRL: 0.
  - ROL: work[W-1].
  - ROR: work[0].
  - ROL uses the SLL step and ROR the SRL step.
  - At each edge: work<=alu_rslt, carry<=alu_sc_o, cnt<=cnt-1.
  - When cnt==1 at the edge -> DONE.
- DONE: rsp_valid=1, with rsp_data=work, rsp_carry=carry and rsp_zero=(work==0), all registered. On rsp_ready -> IDLE.
- Outside RUN, alu_cmd=000, alu_a=alu_b=0, alu_sc_i=0. ALU outputs are ignored outside RUN.
- No pipelining: one request in flight. A new request is accepted no earlier than the cycle after response acceptance, when req_ready is high again.

## Timing
- Reset values (async, rst_n low):
  - state=IDLE, req_ready=1.
  - rsp_valid=0, rsp_data=0, rsp_carry=0, rsp_zero=1, rsp_err=0.
  - alu_cmd=000, sel_cmd=00, alu_a=alu_b=0, alu_sc_i=0.
- Accept edge = first rising edge with req_valid && req_ready.
- Latency from accept edge to rsp_valid:
  - logic op: 1 further edge.
  - shift with amt=k≥1: k further edges.
  - amt=0 or illegal op: rsp_valid high right after the accept edge.
- rsp_valid and all rsp_* stay stable until the rising edge where rsp_ready=1. At that edge -> IDLE, and rsp_valid drops.
- rsp_ready held high in DONE: one response per request. req_ready is 0 in the DONE cycle, so there is no same-cycle turnaround.
- req_* changes while not in IDLE are ignored; the registered copies are used.
- rst_n asserted mid-RUN or mid-DONE aborts immediately to reset values. The in-flight response is lost and no partial rsp_valid is emitted.
- Count arithmetic is unsigned AMT_W bits. The maximum amt (7) runs 7 steps, with no wrap.

## Test plan
- Reset mid-RUN: SLL a=0x01 amt=7, assert rst_n low at the third RUN cycle -> all outputs equal the reset values; the next request is processed normally.
- SLL a=0x81 amt=1 -> rsp after 1 RUN edge: data=0x02, carry=1, zero=0. SRL a=0x81 amt=3 -> data=0x10, carry=0, rsp_valid after 3 RUN edges.
- ROL a=0x96 amt=3 -> data=0xB4, carry=0. ROR a=0x01 amt=1 -> data=0x80, carry=1. Check alu_sc_i equals work[W-1] or work[0] each RUN cycle.
- XOR a=0x5A b=0x5A -> data=0x00, zero=1, carry=0, after 1 RUN edge. AND a=0xF0 b=0x3C -> data=0x30.
- Edge cases: SLL amt=0 a=0x7F -> rsp_valid right after the accept edge, data=0x7F, carry=0. Illegal op=111 -> err=1, data=0, zero=1.
- Backpressure: rsp_ready low for 5 cycles in DONE -> rsp_* stable, req_ready=0, a new req_valid is ignored. Raise rsp_ready -> IDLE next cycle and the new request is then accepted.
